// File: rtl/y_alu_pkg.sv
// Shared definitions for the y_alu_arb slice: ALU op codes, sequencer state type
// and op legality helper.
package y_alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic {
        ST_IDLE,
        ST_RESP
    } state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) ||
               (op == ALU_SUB) || (op == ALU_SLT);
    endfunction

endpackage

// File: rtl/y_alu_core.sv
// Single-cycle combinational ALU: AND/OR/ADD/SUB/SLT; illegal ops yield z=0 with err set.
module y_alu_core
    import y_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_op,
    output logic [WIDTH-1:0] o_z,
    output logic             o_zero,
    output logic             o_err
);

    logic [WIDTH-1:0] w_diff;
    logic             w_lt;

    assign w_diff = i_a - i_b;
    // Differing signs: the negative operand is smaller; otherwise the difference cannot overflow.
    assign w_lt   = (i_a[WIDTH-1] != i_b[WIDTH-1]) ? i_a[WIDTH-1] : w_diff[WIDTH-1];

    always_comb begin
        o_z = '0;
        case (i_op)
            ALU_AND: o_z = i_a & i_b;
            ALU_OR:  o_z = i_a | i_b;
            ALU_ADD: o_z = i_a + i_b;
            ALU_SUB: o_z = w_diff;
            ALU_SLT: o_z = {{(WIDTH-1){1'b0}}, w_lt};
            default: o_z = '0;
        endcase
    end

    assign o_zero = (o_z == '0);
    assign o_err  = !is_legal_op(i_op);

endmodule

// File: rtl/y_alu_arb.sv
// Two-requester arbiter/sequencer around one shared ALU with a registered, backpressured result.
// Define Y_ALU_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module y_alu_arb
    import y_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_z,
    output logic             rsp_zero,
    output logic             rsp_err
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_owner;
    logic [WIDTH-1:0] r_z;
    logic             r_zero;
    logic             r_err;

    logic             w_tie_pick1;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_rsp_fire;
    logic             w_slot_free;
    logic             w_accept;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [2:0]       w_op;
    logic [WIDTH-1:0] w_z;
    logic             w_zero;
    logic             w_err;

`ifdef Y_ALU_ARB_RR_EN
    // Remembers the requester granted at the most recent accept; ties go to the other one.
    logic r_rr_ptr;

    assign w_tie_pick1 = ~r_rr_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= 1'b1;
        end else if (w_accept) begin
            r_rr_ptr <= w_gnt1;
        end
    end
`else
    assign w_tie_pick1 = 1'b0;
`endif

    assign w_gnt1 = req1_valid && (!req0_valid || w_tie_pick1);
    assign w_gnt0 = req0_valid && !w_gnt1;

    // Only the owner's rsp_ready matters, so the non-owner cannot influence request readiness.
    assign w_rsp_fire  = (r_state == ST_RESP) && (r_owner ? rsp1_ready : rsp0_ready);
    assign w_slot_free = rst_n && ((r_state == ST_IDLE) || w_rsp_fire);
    assign req0_ready  = w_gnt0 && w_slot_free;
    assign req1_ready  = w_gnt1 && w_slot_free;
    assign w_accept    = (w_gnt0 || w_gnt1) && w_slot_free;

    assign w_a  = w_gnt1 ? req1_a  : req0_a;
    assign w_b  = w_gnt1 ? req1_b  : req0_b;
    assign w_op = w_gnt1 ? req1_op : req0_op;

    y_alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_a    (w_a),
        .i_b    (w_b),
        .i_op   (w_op),
        .o_z    (w_z),
        .o_zero (w_zero),
        .o_err  (w_err)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_RESP;
            ST_RESP: begin
                if (w_accept)        w_state_nxt = ST_RESP;
                else if (w_rsp_fire) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_z     <= '0;
            r_zero  <= 1'b0;
            r_err   <= 1'b0;
            r_owner <= 1'b0;
        end else if (w_accept) begin
            r_z     <= w_z;
            r_zero  <= w_zero;
            r_err   <= w_err;
            r_owner <= w_gnt1;
        end
    end

    assign rsp0_valid = (r_state == ST_RESP) && !r_owner;
    assign rsp1_valid = (r_state == ST_RESP) && r_owner;
    assign rsp_z      = r_z;
    assign rsp_zero   = r_zero;
    assign rsp_err    = r_err;

endmodule

// File: doc/y_alu_arb.md
# y_alu_arb

Two-requester arbiter and sequencer for the shared single-cycle ALU. It accepts operations from requester 0 (execute path) and requester 1 (branch/compare path) over valid/ready handshakes. It evaluates the granted operation through the ALU core, registers the result, and returns it to the owning requester with independent response backpressure. Throughput is one operation per cycle; each operation has one cycle of latency.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid also high
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- req0_op / req1_op  in  3  ALU op code
- rsp0_valid / rsp1_valid  out  1  result held for requester 0 / 1 (never both high)
- rsp0_ready / rsp1_ready  in  1  requester consumes result
- rsp_z  out  WIDTH  registered result (shared by both response channels)
- rsp_zero  out  1  registered: rsp_z == 0
- rsp_err  out  1  registered: op was illegal

## Operation
- Op codes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
  - ADD/SUB wrap mod 2^WIDTH.
  - SLT gives signed a<b as value 1 or 0, with overflow handled (sign-differ case uses a[MSB]).
- Illegal ops 011, 100, 101 give z=0, zero=1, err=1; they are still returned normally.
- States: IDLE (no result held) and RESP (result held, owner recorded).
- Grant (combinational, from both valids):
  - Only one valid: that requester is granted.
  - Both valid: priority rule (see Configuration) picks one.
- Ready:
  - reqN_ready = grantN && (IDLE || (RESP && rsp_fire)).
  - rsp_fire = rspOwner_valid && rspOwner_ready.
  - Ready may depend on both valids; it must not depend on rsp_ready of the non-owner.
- On accept: ALU evaluates the granted operands; z/zero/err and the owner are loaded into the result register; state becomes RESP.
- In RESP:
  - rsp_fire and no accept: go to IDLE, drop rspN_valid.
  - rsp_fire and accept in the same cycle: stay in RESP, load the new result and owner (back-to-back).
  - No rsp_fire: hold rsp_z/zero/err/owner stable; both req_ready are low.
- Reset values: state IDLE, rsp0_valid=rsp1_valid=0, rsp_z=0, rsp_zero=0, rsp_err=0, owner=0, RR pointer=1 (requester 0 wins first tie).

## Timing
- Accept at edge N (valid&ready during cycle N) gives rspN_valid high from cycle N+1.
- Sustained rate: 1 op/cycle if the owner's rsp_ready is held high.
- Requesters must hold valid/operands/op stable until ready. The block does not check this.
- rst_n low at an edge overrides everything:
  - any held result is discarded and no response appears afterward;
  - requests presented during reset cycles are not accepted (ready=0 while rst_n=0).
- Owner's rsp_ready low for k cycles stalls both request channels for k cycles.

## Configuration
- Y_ALU_ARB_RR_EN defined:
  - Round-robin on ties: grant the requester not granted at the most recent accept.
  - The pointer updates only on accept.
- Not defined:
  - Fixed priority: requester 0 always wins ties. Requester 1 can starve.
  - The pointer logic is absent.

## Structure
- Package y_alu_pkg:
  - op constants ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT;
  - state type {ST_IDLE, ST_RESP};
  - function is_legal_op.
- Sub-module y_alu_core:
  - purely combinational, parameter WIDTH;
  - inputs a, b, op; outputs z, zero, err;
  - one instance, fed by the grant mux.
- The arbiter, state register, result register and RR pointer live in y_alu_arb.

## Test plan
- Reset, then req0 ADD a=5 b=7, rsp0_ready=1 -> rsp0_valid in the next cycle with rsp_z=12, zero=0, err=0; rsp1_valid stays 0.
- Both valid: req0 SUB 3-3 and req1 SLT -1<1, both held for 2 cycles, rsp ready high.
  - RR_EN: req0 first (z=0, zero=1), then req1 (z=1).
  - Fixed priority: req0 wins both cycles.
- Back-to-back: req1 OR 0xF0|0x0F, then req1 AND 0xFF&0x0F on consecutive cycles, rsp1_ready=1 -> rsp_z 0xFF then 0x0F on consecutive cycles; req1_ready never drops.
- Backpressure: accept req0 ADD 0x7FFFFFFF+1, rsp0_ready=0 for 3 cycles while req1 valid.
  - rsp_z must read 0x80000000 and stay stable; req1_ready must stay 0.
  - When rsp0_ready rises, req1 is accepted in that same cycle.
- Illegal op 100 on req0 -> rsp_z=0, zero=1, err=1, normal handshake.
- Reset while in RESP with rsp0_ready=0 -> next cycle rsp0_valid=0, rsp_z=0, state IDLE; a following req0 is accepted normally.
